// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin owner select for a downstream 2:1 mux.
// Grants one of two requesters at a time. A burst is bounded to MAX_HOLD
// cycles when the other source is waiting. sel only moves on a real owner
// change, so the mux never sees a needless toggle.
// Optional feature: define MUX_SEL_LOCK_EN to add lock_i. While lock_i is
// high, the forced switch is suppressed and the hold counter is frozen.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
`ifdef MUX_SEL_LOCK_EN
  input  logic       lock_i,
`endif
  output logic [1:0] grant_o,
  output logic       sel_o,
  output logic       busy_o,
  output logic       switched_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             sw_q, sw_d;
  logic             lock_w;

`ifdef MUX_SEL_LOCK_EN
  assign lock_w = lock_i;
`else
  assign lock_w = 1'b0;
`endif

  // State and registered-output flops; reset leaves last=1 so source 0 wins the first tie
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      sw_q    <= sw_d;
    end
  end

  // Next owner, hold counter and tie-break memory
  always_comb begin
    logic   own_req;
    logic   oth_req;
    state_e oth_st;
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    own_req = 1'b0;
    oth_req = 1'b0;
    oth_st  = IDLE;
    sel_d   = sel_q;
    sw_d    = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        case (req_i)
          2'b01:   state_d = G0;
          2'b10:   state_d = G1;
          2'b11:   state_d = last_q ? G0 : G1;
          default: state_d = IDLE;
        endcase
      end
      G0, G1: begin
        own_req = (state_q == G1) ? req_i[1] : req_i[0];
        oth_req = (state_q == G1) ? req_i[0] : req_i[1];
        oth_st  = (state_q == G1) ? G0 : G1;
        if (!own_req) begin
          // Owner released: hand over directly, or go idle
          hold_d  = '0;
          state_d = oth_req ? oth_st : IDLE;
        end else if (lock_w) begin
          // Locked burst: keep owner, counter frozen
          hold_d = hold_q;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (oth_req) state_d = oth_st;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
    if (state_d != state_q) begin
      if (state_d == G0) last_d = 1'b0;
      if (state_d == G1) last_d = 1'b1;
    end
    // sel tracks the owner and holds through IDLE
    if (state_d == G1) sel_d = 1'b1;
    if (state_d == G0) sel_d = 1'b0;
    sw_d = (state_q != IDLE) && (state_d != IDLE) && (state_d != state_q);
  end

  // Outputs decoded from registered state
  always_comb begin
    grant_o    = 2'b00;
    if (state_q == G0) grant_o = 2'b01;
    if (state_q == G1) grant_o = 2'b10;
    busy_o     = (state_q != IDLE);
    sel_o      = sel_q;
    switched_o = sw_q;
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed + random bench for mux_sel_arbiter with a scoreboard queue.
module tb_mux_sel_arbiter;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic       lock;
  logic [1:0] grant;
  logic       sel, busy, switched;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_HOLD(MH), .CNT_W(3)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
`ifdef MUX_SEL_LOCK_EN
    .lock_i     (lock),
`endif
    .grant_o    (grant),
    .sel_o      (sel),
    .busy_o     (busy),
    .switched_o (switched)
  );

  typedef struct packed {
    logic [1:0] grant;
    logic       sel;
    logic       busy;
    logic       sw;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // reference model: 0=idle, 1=owner0, 2=owner1
  int   m_st = 0, m_cnt = 0, m_last = 1, m_sel = 0, m_sw = 0;

  task automatic model_edge(input logic r_n, input logic [1:0] rq, input logic lk);
    int ns, nc, me, other;
    logic mine, theirs;
    ns = m_st; nc = m_cnt;
    if (!r_n) begin
      m_st = 0; m_cnt = 0; m_last = 1; m_sel = 0; m_sw = 0;
      return;
    end
    if (m_st == 0) begin
      nc = 0;
      if (rq == 2'b01)      ns = 1;
      else if (rq == 2'b10) ns = 2;
      else if (rq == 2'b11) ns = (m_last == 0) ? 2 : 1;
      else                  ns = 0;
    end else begin
      me     = m_st - 1;
      other  = 1 - me;
      mine   = rq[me];
      theirs = rq[other];
`ifndef MUX_SEL_LOCK_EN
      lk = 1'b0;
`endif
      if (!mine) begin
        nc = 0;
        ns = theirs ? other + 1 : 0;
      end else if (lk) begin
        nc = m_cnt;
      end else if (m_cnt == MH - 1) begin
        nc = 0;
        if (theirs) ns = other + 1;
      end else begin
        nc = m_cnt + 1;
      end
    end
    m_sw = (m_st != 0 && ns != 0 && ns != m_st) ? 1 : 0;
    if (ns != 0 && ns != m_st) m_last = ns - 1;
    if (ns == 1) m_sel = 0;
    if (ns == 2) m_sel = 1;
    m_st = ns; m_cnt = nc;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.grant = (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00;
    e.sel   = m_sel[0];
    e.busy  = (m_st != 0);
    e.sw    = m_sw[0];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  // drive at negedge, push expectation, compare after the edge
  task automatic step(input logic r_n, input logic [1:0] rq, input logic lk);
    exp_t e;
    @(negedge clk);
    rst_n = r_n; req = rq; lock = lk;
    model_edge(r_n, rq, lk);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 2'b01, 2'b00);
    end else begin
      e = exp_q.pop_front();
      chk("grant",    grant,           e.grant);
      chk("sel",      {1'b0, sel},     {1'b0, e.sel});
      chk("busy",     {1'b0, busy},    {1'b0, e.busy});
      chk("switched", {1'b0, switched},{1'b0, e.sw});
      chk("onehot",   {1'b0, grant == 2'b11}, 2'b00);
    end
  endtask

  initial begin
    int seen_switch;
    rst_n = 1'b0; req = 2'b11; lock = 1'b0;

    // reset with both requesting
    repeat (3) step(1'b0, 2'b11, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_sel",   {1'b0, sel}, 2'b00);

    // burst: 01 on edges 1-4, 10 on 5-8, 01 on 9
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 2'b11, 1'b0);
      if (i <= 4)      chk("burst_g0", grant, 2'b01);
      else if (i <= 8) chk("burst_g1", grant, 2'b10);
      else             chk("burst_back", grant, 2'b01);
      if (i == 5 || i == 9) chk("burst_sw", {1'b0, switched}, 2'b01);
    end
    // run on until G1 again
    repeat (4) step(1'b1, 2'b11, 1'b0);
    chk("in_g1", grant, 2'b10);
    // owner release: direct handover then idle with sel held at 0
    step(1'b1, 2'b01, 1'b0);
    chk("release_g", grant, 2'b01);
    chk("release_sw", {1'b0, switched}, 2'b01);
    step(1'b1, 2'b00, 1'b0);
    chk("idle_g", grant, 2'b00);
    chk("idle_sel0", {1'b0, sel}, 2'b00);
    // sel holds 1 through idle after G1
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    chk("idle_sel1", {1'b0, sel}, 2'b01);
    chk("idle_nosw", {1'b0, switched}, 2'b00);

    // single source held 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'b01, 1'b0);
      chk("single_g", grant, 2'b01);
    end
    step(1'b1, 2'b00, 1'b0);

    // reset mid-burst in G1 with hold count 2
    repeat (3) step(1'b1, 2'b10, 1'b0);
    step(1'b0, 2'b11, 1'b0);
    chk("midrst_g", grant, 2'b00);
    chk("midrst_sel", {1'b0, sel}, 2'b00);
    step(1'b1, 2'b11, 1'b0);
    chk("midrst_first", grant, 2'b01);

`ifdef MUX_SEL_LOCK_EN
    // locked burst holds owner well past MAX_HOLD
    step(1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 2'b11, 1'b1);
      chk("lock_hold", grant, 2'b01);
    end
    seen_switch = 0;
    for (int i = 0; i < MH; i++) begin
      step(1'b1, 2'b11, 1'b0);
      if (grant == 2'b10) seen_switch = 1;
    end
    chk("unlock_switch", seen_switch[1:0], 2'b01);
`else
    seen_switch = 0;
`endif

    // random traffic with occasional reset and lock
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 29) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
